wb_stage_buf: RTL and testbench
===============================

Name: wb_stage_buf

Overview:
- Parametrised write-back stage for the pipelined MIPS-style core.
- Selects the result source per instruction (ALU, load, link, immediate) and aligns and extends sub-word load data.
- Queues register-file writes in a small skid buffer so the MEM stage can keep retiring while the shared register-file write port is busy.
- Sits between MEM stage and register file; optionally exposes a bypass lookup for the decode-stage hazard unit.

Parameters:
DATA_W, 16, datapath width; multiple of 8.
REG_AW, 3, register address width.
SKID_DEPTH, 2, pending-write buffer entries; power of two, >=2.
ZERO_REG_DISCARD, 1, 1 = writes to register 0 are consumed but never queued.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept this cycle
wb_en  in  1  instruction writes a register
wb_dest_in  in  REG_AW  destination register
src_sel  in  2  0=ALU, 1=MEM, 2=LINK, 3=IMM
alu_res  in  DATA_W  ALU result
mem_res  in  DATA_W  raw memory read word
link_val  in  DATA_W  return address
imm_val  in  DATA_W  immediate
mem_byte  in  1  1 = byte load, 0 = full word
mem_signed  in  1  sign-extend byte loads
mem_off  in  max(1,$clog2(DATA_W/8))  byte lane of the load
flush  in  1  discard all queued writes
regfile_ready  in  1  register-file port accepts a write
regfile_en  out  1  write request valid
wb_dest  out  REG_AW  write address
wb_data  out  DATA_W  write data
stall_cnt  out  CNT_W  cycles with regfile_en=1 and regfile_ready=0, saturating

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values:
  - All of the following are 0: regfile_en, wb_dest, wb_data, stall_cnt, pointers, count.
  - in_ready=0 while rst=1.
- Accept condition: in_valid && in_ready.
  - in_ready = !rst && !flush && (count < SKID_DEPTH). No pass-through on a same-cycle pop.
- Push rule: an accepted instruction pushes {dest, data} only if wb_en=1 and not (ZERO_REG_DISCARD && wb_dest_in==0). Otherwise it is consumed silently.
- Data selection:
  - src_sel 0/2/3 selects alu_res, link_val or imm_val respectively.
  - src_sel 1 selects mem_res when mem_byte=0.
  - When mem_byte=1: lane mem_off (bits 8*off+7:8*off) goes to bits 7:0. The upper bits are filled with lane bit 7 if mem_signed, else 0.
- Latency: accepted at edge n, so regfile_en/wb_dest/wb_data are visible in the cycle after edge n.
- Outputs are driven from buffer flops through a read-pointer mux. There is no combinational path from any input except rst.
- Output order:
  - regfile_en = (count != 0).
  - The head entry is held stable until regfile_en && regfile_ready, which pops it.
  - FIFO order is strict.
- Simultaneous push and pop: count is unchanged; pointers advance modulo SKID_DEPTH.
- flush:
  - Synchronous: count, wr_ptr and rd_ptr are cleared, so regfile_en=0 in the next cycle.
  - Any pop or push in the flush cycle is ignored.
  - stall_cnt is not cleared.
- stall_cnt: increments when regfile_en && !regfile_ready and saturates at all-ones. It is cleared only by rst.
- Reset mid-operation: the buffer is emptied immediately and the entries are lost.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, the block adds these ports:
  - byp_addr (in, REG_AW)
  - byp_hit (out, 1)
  - byp_data (out, DATA_W)
- Lookup: byp_hit=1 when any queued entry has dest==byp_addr. byp_data is the youngest matching entry.
- Address 0 never hits when ZERO_REG_DISCARD=1.
- The lookup is combinational from byp_addr and the buffer flops.
- When undefined: the ports are absent and there is no comparator logic.

Decomposition:
- Package wb_pkg holds:
  - src_sel encoding constants: SRC_ALU, SRC_MEM, SRC_LINK, SRC_IMM.
  - Entry struct {dest, data}, parametrised by width localparams.
- Sub-module wb_load_align: combinational lane select and extension. It takes mem_res, mem_byte, mem_signed and mem_off.

Test Plan:
- ALU write: in_valid=1, src_sel=0, alu_res=0x1234, dest=3, regfile_ready=1 -> the next cycle shows regfile_en=1, wb_dest=3, wb_data=0x1234, and the entry pops that cycle.
- Byte loads: mem_res=0x80F0, mem_byte=1, mem_off=1.
  - mem_signed=1 -> wb_data=0xFF80.
  - mem_signed=0 -> wb_data=0x0080.
  - mem_off=0, mem_signed=1 -> wb_data=0xFFF0.
- Backpressure: regfile_ready=0 with 3 back-to-back pushes (dests 1,2,3) -> in_ready drops after 2 accepts and stall_cnt counts each cycle. When regfile_ready is raised, writes 1 then 2 drain in order, then dest 3 is accepted.
- Discard: wb_en=0, or dest=0 with ZERO_REG_DISCARD=1 -> accepted with in_ready=1 and no regfile_en pulse.
- Flush/reset: buffer holds 2 entries, flush=1 for one cycle -> regfile_en=0 the next cycle and in_ready=0 during flush. Asserting rst asynchronously clears all outputs within the same cycle.
- WB_BYPASS_EN: queue dest 5 = 0x0011, then dest 5 = 0x0022, with regfile_ready=0, byp_addr=5 -> byp_hit=1, byp_data=0x0022. byp_addr=6 -> byp_hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: result-source encodings,
// the queued-write entry type and the load-lane width helper.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_REG_AW = 3;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  typedef struct packed {
    logic [WB_REG_AW-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Byte-lane index width; a single-lane datapath still gets a 1-bit index.
  function automatic int unsigned off_width(input int unsigned data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Sub-word load alignment: picks the addressed byte lane of the memory word
// and sign- or zero-extends it; full-word loads pass through unchanged.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OFF_W  = off_width(DATA_W)
) (
  input  logic [DATA_W-1:0] mem_res,
  input  logic              mem_byte,
  input  logic              mem_signed,
  input  logic [OFF_W-1:0]  mem_off,
  output logic [DATA_W-1:0] load_data
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [7:0] lane;

  always_comb begin
    lane = mem_res[7:0];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mem_off == OFF_W'(i)) begin
        lane = mem_res[8*i +: 8];
      end
    end
  end

  always_comb begin
    load_data = mem_res;
    if (mem_byte) begin
      // Fill everything with the extension bit, then drop the lane into the low byte.
      load_data      = {DATA_W{mem_signed & lane[7]}};
      load_data[7:0] = lane;
    end
  end

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage with a small skid buffer in front of the register-file port.
// Define WB_BYPASS_EN to add the byp_addr/byp_hit/byp_data lookup for the hazard unit.
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned REG_AW           = 3,
  parameter int unsigned SKID_DEPTH       = 2,
  parameter bit          ZERO_REG_DISCARD = 1'b1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         wb_en,
  input  logic [REG_AW-1:0]            wb_dest_in,
  input  logic [1:0]                   src_sel,
  input  logic [DATA_W-1:0]            alu_res,
  input  logic [DATA_W-1:0]            mem_res,
  input  logic [DATA_W-1:0]            link_val,
  input  logic [DATA_W-1:0]            imm_val,
  input  logic                         mem_byte,
  input  logic                         mem_signed,
  input  logic [off_width(DATA_W)-1:0] mem_off,
  input  logic                         flush,
  input  logic                         regfile_ready,
  output logic                         regfile_en,
  output logic [REG_AW-1:0]            wb_dest,
  output logic [DATA_W-1:0]            wb_data,
`ifdef WB_BYPASS_EN
  input  logic [REG_AW-1:0]            byp_addr,
  output logic                         byp_hit,
  output logic [DATA_W-1:0]            byp_data,
`endif
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned OFF_W    = off_width(DATA_W);
  localparam int unsigned PTR_W    = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(SKID_DEPTH);

  logic [REG_AW-1:0]   dest_q [SKID_DEPTH];
  logic [DATA_W-1:0]   data_q [SKID_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_W-1:0]    stall_q;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   sel_data;
  logic                accept;
  logic                push;
  logic                pop;

  wb_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .mem_res    (mem_res),
    .mem_byte   (mem_byte),
    .mem_signed (mem_signed),
    .mem_off    (mem_off),
    .load_data  (load_data)
  );

  always_comb begin
    sel_data = alu_res;
    case (src_sel)
      SRC_ALU:  sel_data = alu_res;
      SRC_MEM:  sel_data = load_data;
      SRC_LINK: sel_data = link_val;
      SRC_IMM:  sel_data = imm_val;
      default:  sel_data = alu_res;
    endcase
  end

  // Ready depends only on occupancy, never on a pop in the same cycle.
  assign in_ready = !rst && !flush && (count_q < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign push     = accept && wb_en && !(ZERO_REG_DISCARD && (wb_dest_in == '0));
  assign pop      = regfile_en && regfile_ready && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      dest_q[wr_ptr_q] <= wb_dest_in;
      data_q[wr_ptr_q] <= sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (regfile_en && !regfile_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign regfile_en = (count_q != '0);
  assign wb_dest    = dest_q[rd_ptr_q];
  assign wb_data    = data_q[rd_ptr_q];
  assign stall_cnt  = stall_q;

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int unsigned k = 0; k < SKID_DEPTH; k++) begin
      byp_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_BITS'(k) < count_q) && (dest_q[byp_idx] == byp_addr) &&
          !(ZERO_REG_DISCARD && (byp_addr == '0))) begin
        byp_hit  = 1'b1;
        byp_data = data_q[byp_idx];
      end
    end
  end
`else
  // No bypass lookup in this build.
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: stimulus queues expected writes, a
// negedge monitor checks each write the DUT hands to the register file.
module tb_wb_stage_buf;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_dest_in = '0;
  logic [1:0]  src_sel = '0;
  logic [15:0] alu_res = 16'h1234;
  logic [15:0] mem_res = '0;
  logic [15:0] link_val = 16'h5678;
  logic [15:0] imm_val = 16'h9ABC;
  logic        mem_byte = 1'b0;
  logic        mem_signed = 1'b0;
  logic [0:0]  mem_off = '0;
  logic        flush = 1'b0;
  logic        regfile_ready = 1'b1;
  logic        regfile_en;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic [15:0] stall_cnt;
`ifdef WB_BYPASS_EN
  logic [2:0]  byp_addr = '0;
  logic        byp_hit;
  logic [15:0] byp_data;
`endif

  wb_stage_buf dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wb_en         (wb_en),
    .wb_dest_in    (wb_dest_in),
    .src_sel       (src_sel),
    .alu_res       (alu_res),
    .mem_res       (mem_res),
    .link_val      (link_val),
    .imm_val       (imm_val),
    .mem_byte      (mem_byte),
    .mem_signed    (mem_signed),
    .mem_off       (mem_off),
    .flush         (flush),
    .regfile_ready (regfile_ready),
    .regfile_en    (regfile_en),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
`ifdef WB_BYPASS_EN
    .byp_addr      (byp_addr),
    .byp_hit       (byp_hit),
    .byp_data      (byp_data),
`endif
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  wb_entry_t exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write the DUT pops must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && regfile_en && regfile_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: got dest %0d data %h expected no write (t=%0t)",
                 wb_dest, wb_data, $time);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        chk("wb_dest", 32'(wb_dest), 32'(e.dest));
        chk("wb_data", 32'(wb_data), 32'(e.data));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic en, input logic [2:0] dest, input logic [1:0] sel,
                       input logic [15:0] mem, input logic bl, input logic sg,
                       input logic off, input logic [15:0] exp, output int tries);
    logic ok;
    in_valid = 1'b1; wb_en = en; wb_dest_in = dest; src_sel = sel;
    mem_res = mem; mem_byte = bl; mem_signed = sg; mem_off = off;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (!ok) tries++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got no accept for dest %0d expected accept", dest);
    end else if (en && dest != 3'd0) begin
      exp_q.push_back('{dest: dest, data: exp});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_regfile_en", 32'(regfile_en), 0);
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU write: visible the cycle after accept, popped that cycle
    issue(1'b1, 3'd3, SRC_ALU, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    @(negedge clk);
    chk("alu_latency_en", 32'(regfile_en), 1);
    chk("alu_latency_dest", 32'(wb_dest), 3);
    chk("alu_latency_data", 32'(wb_data), 32'h1234);
    @(negedge clk);
    chk("alu_popped", 32'(regfile_en), 0);
    @(posedge clk);
    #1;

    // Source select and load alignment
    issue(1'b1, 3'd4, SRC_LINK, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h5678, t);
    issue(1'b1, 3'd5, SRC_IMM,  16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h9ABC, t);
    issue(1'b1, 3'd6, SRC_MEM,  16'h80F0, 1'b0, 1'b0, 1'b0, 16'h80F0, t);
    issue(1'b1, 3'd1, SRC_MEM,  16'h80F0, 1'b1, 1'b1, 1'b1, 16'hFF80, t);
    issue(1'b1, 3'd2, SRC_MEM,  16'h80F0, 1'b1, 1'b0, 1'b1, 16'h0080, t);
    issue(1'b1, 3'd7, SRC_MEM,  16'h80F0, 1'b1, 1'b1, 1'b0, 16'hFFF0, t);
    issue(1'b1, 3'd3, SRC_MEM,  16'h80F0, 1'b1, 1'b0, 1'b0, 16'h00F0, t);
    drain();

    // Backpressure: two accepts fill the buffer, third waits
    regfile_ready = 1'b0;
    issue(1'b1, 3'd1, SRC_ALU, 16'h0, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    chk("bp_accept1_tries", 32'(t), 0);
    issue(1'b1, 3'd2, SRC_LINK, 16'h0, 1'b0, 1'b0, 1'b0, 16'h5678, t);
    chk("bp_accept2_tries", 32'(t), 0);
    in_valid = 1'b1; wb_en = 1'b1; wb_dest_in = 3'd3; src_sel = SRC_IMM;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_in_ready", 32'(in_ready), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_stall_cnt", 32'(stall_cnt), 4);
    @(posedge clk);
    #1 regfile_ready = 1'b1;
    issue(1'b1, 3'd3, SRC_IMM, 16'h0, 1'b0, 1'b0, 1'b0, 16'h9ABC, t);
    chk("bp_accept3_tries", 32'(t), 1);
    drain();
    chk("bp_stall_final", 32'(stall_cnt), 5);

    // Discards: no write, no stall, accepted at once
    issue(1'b0, 3'd4, SRC_ALU, 16'h0, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    chk("discard_wben_tries", 32'(t), 0);
    issue(1'b1, 3'd0, SRC_ALU, 16'h0, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    chk("discard_r0_tries", 32'(t), 0);
    @(negedge clk);
    chk("discard_no_en", 32'(regfile_en), 0);
    @(negedge clk);
    chk("discard_no_en2", 32'(regfile_en), 0);
    @(posedge clk);
    #1;

    // Flush with two entries queued
    regfile_ready = 1'b0;
    issue(1'b1, 3'd1, SRC_ALU, 16'h0, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    issue(1'b1, 3'd2, SRC_LINK, 16'h0, 1'b0, 1'b0, 1'b0, 16'h5678, t);
    flush = 1'b1; in_valid = 1'b1; wb_en = 1'b1; wb_dest_in = 3'd6; src_sel = SRC_ALU;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_regfile_en", 32'(regfile_en), 0);
    chk("flush_keeps_stall", 32'(stall_cnt), 7);
    @(posedge clk);
    #1 regfile_ready = 1'b1;
    issue(1'b1, 3'd2, SRC_IMM, 16'h0, 1'b0, 1'b0, 1'b0, 16'h9ABC, t);
    drain();

    // Asynchronous reset mid-operation
    regfile_ready = 1'b0;
    issue(1'b1, 3'd5, SRC_ALU, 16'h0, 1'b0, 1'b0, 1'b0, 16'h1234, t);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_regfile_en", 32'(regfile_en), 0);
    chk("arst_wb_dest", 32'(wb_dest), 0);
    chk("arst_wb_data", 32'(wb_data), 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0; regfile_ready = 1'b1;
    issue(1'b1, 3'd3, SRC_LINK, 16'h0, 1'b0, 1'b0, 1'b0, 16'h5678, t);
    drain();

`ifdef WB_BYPASS_EN
    regfile_ready = 1'b0;
    imm_val = 16'h0011;
    issue(1'b1, 3'd5, SRC_IMM, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0011, t);
    imm_val = 16'h0022;
    issue(1'b1, 3'd5, SRC_IMM, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0022, t);
    byp_addr = 3'd5;
    #1;
    chk("byp_hit5", 32'(byp_hit), 1);
    chk("byp_data5", 32'(byp_data), 32'h0022);
    byp_addr = 3'd6;
    #1;
    chk("byp_miss6", 32'(byp_hit), 0);
    byp_addr = 3'd0;
    #1;
    chk("byp_miss0", 32'(byp_hit), 0);
    imm_val = 16'h9ABC;
    @(posedge clk);
    #1 regfile_ready = 1'b1;
    drain();
`endif

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
